// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter feeding one FIFO write port.
// Locks one requester for a burst of up to MAXBURST words or until packet end.
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(MAXBURST) + 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         owner,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] nxt_ptr;
  logic [CW-1:0] cnt_inc;
  logic          rel;
  int            k;

  // Round-robin search: first set req bit at or above prio, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(prio_q) + i) % NREQ;
      if (!pick_found && req[k]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(k);
      end
    end
  end

  assign busy    = (state_q == LOCK);
  assign owner   = owner_q;
  assign winc    = busy & req[owner_q] & ~wfull;
  assign gnt     = winc ? (NREQ'(1) << owner_q) : '0;
  assign wdata   = busy ? req_data[owner_q*DSIZE +: DSIZE] : '0;
  assign cnt_inc = cnt_q + 1'b1;
  assign rel     = winc &
                   (req_last[owner_q] | (cnt_inc == CW'(MAXBURST)));
  assign nxt_ptr = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  // Next-state: lock onto the picked requester, release on last/max burst.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (winc) begin
          cnt_d = cnt_inc;
        end
        if (rel) begin
          state_d = IDLE;
          prio_d  = nxt_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst immediately.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
